// File: rtl/beamformer_pkg.sv
// ---------------------------------------------------------------------------
// beamformer_pkg
// Shared constants and types for the delay-and-sum beamformer controller.
//   NUM_CHANNELS   : number of channel buffers walked per frame (1..8)
//   NUMBER_OF_BITS : two's complement sample width
//   BUFFER_SIZE    : depth of each channel buffer
//   IDX_W          : read-index width (one spare bit so the serial shadow can
//                    hold values past the buffer end; those get clamped)
//   SUM_W          : beam-sum width, wide enough that the sum never overflows
// ---------------------------------------------------------------------------
package beamformer_pkg;

  localparam int NUM_CHANNELS   = 2;
  localparam int NUMBER_OF_BITS = 8;
  localparam int BUFFER_SIZE    = 16;
  localparam int IDX_W          = $clog2(BUFFER_SIZE) + 1;
  localparam int SUM_W          = NUMBER_OF_BITS + $clog2(NUM_CHANNELS);

  // The config select field is 3 bits, so storage is sized for 8 channels.
  localparam int CH_W   = 3;
  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Limit a shadow delay to the last valid buffer slot.
  function automatic logic [IDX_W-1:0] clamp_index(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] lim;
    lim = IDX_W'(BUFFER_SIZE - 1);
    if (v > lim) begin
      return lim;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/cfg_edge_sync.sv
// ---------------------------------------------------------------------------
// cfg_edge_sync
// Brings the slow serial config pins into the clk domain.
//   clk_i, rst_ni : system clock, synchronous active-low reset
//   cfg_clk_i     : serial config clock from pin (asynchronous)
//   cfg_data_i    : serial config data bit
//   cfg_sel_i     : target channel of the shift
//   rise_o        : one-cycle pulse per rising edge of the synced cfg clock
//   data_o, sel_o : synced data/select, aligned with rise_o
// Every pin goes through the same two-flop chain, so data and select captured
// alongside a clock edge stay aligned with that edge.
// ---------------------------------------------------------------------------
module cfg_edge_sync #(
  parameter int SEL_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_clk_i,
  input  logic             cfg_data_i,
  input  logic [SEL_W-1:0] cfg_sel_i,
  output logic             rise_o,
  output logic             data_o,
  output logic [SEL_W-1:0] sel_o
);

  logic [1:0]       clk_sync_q;
  logic             clk_prev_q;
  logic [1:0]       data_sync_q;
  logic [SEL_W-1:0] sel_meta_q;
  logic [SEL_W-1:0] sel_sync_q;
  logic             rise_q;
  logic             data_q;
  logic [SEL_W-1:0] sel_q;

  // Two-flop synchronizers, edge history and registered aligned outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b00;
      clk_prev_q  <= 1'b0;
      data_sync_q <= 2'b00;
      sel_meta_q  <= '0;
      sel_sync_q  <= '0;
      rise_q      <= 1'b0;
      data_q      <= 1'b0;
      sel_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], cfg_clk_i};
      clk_prev_q  <= clk_sync_q[1];
      data_sync_q <= {data_sync_q[0], cfg_data_i};
      sel_meta_q  <= cfg_sel_i;
      sel_sync_q  <= sel_meta_q;
      rise_q      <= clk_sync_q[1] & ~clk_prev_q;
      data_q      <= data_sync_q[1];
      sel_q       <= sel_sync_q;
    end
  end

  assign rise_o = rise_q;
  assign data_o = data_q;
  assign sel_o  = sel_q;

endmodule

// File: rtl/beam_delay_sequencer.sv
// ---------------------------------------------------------------------------
// beam_delay_sequencer
// Holds per-channel delays loaded over the serial config pins, commits them at
// each frame boundary, then walks the channel buffers once per frame and sums
// the returned samples into a signed beam sum.
//   clk, rst_n      : system clock, synchronous active-low reset
//   frame_strobe    : new sample written into all channel buffers
//   cfg_clk/data/sel: serial delay loading (async to clk), MSB first
//   buf_chan_sel    : channel buffer currently addressed
//   buf_read_index  : read index presented to that buffer
//   buf_data        : combinational read data from that buffer
//   sum_out         : beam sum of the last completed frame
//   sum_valid       : one-cycle pulse when sum_out updates
//   busy            : frame being sequenced
//   frame_overrun   : sticky, frame_strobe arrived while busy
// ---------------------------------------------------------------------------
module beam_delay_sequencer
  import beamformer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_strobe,
  input  logic                      cfg_clk,
  input  logic                      cfg_data,
  input  logic [CH_W-1:0]           cfg_sel,
  output logic [CH_W-1:0]           buf_chan_sel,
  output logic [IDX_W-1:0]          buf_read_index,
  input  logic [NUMBER_OF_BITS-1:0] buf_data,
  output logic [SUM_W-1:0]          sum_out,
  output logic                      sum_valid,
  output logic                      busy,
  output logic                      frame_overrun
);

  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CHANNELS - 1);
  localparam logic [CH_W-1:0] ONE_CH     = CH_W'(1);
  localparam int              NCH_INT    = NUM_CHANNELS;
  localparam logic [CH_W:0]   NUM_CH_EXT = NCH_INT[CH_W:0];

  logic                     cfg_rise_s;
  logic                     cfg_data_s;
  logic [CH_W-1:0]          cfg_sel_s;
  logic [IDX_W-1:0]         shadow_q [MAX_CH];
  logic [IDX_W-1:0]         shadow_d [MAX_CH];
  logic [IDX_W-1:0]         active_q [MAX_CH];
  seq_state_e               state_q;
  logic [CH_W-1:0]          ch_q;
  logic [CH_W-1:0]          ch_next_s;
  logic signed [SUM_W-1:0]  acc_q;
  logic signed [SUM_W-1:0]  data_ext_s;
  logic [CH_W-1:0]          chan_sel_q;
  logic [IDX_W-1:0]         idx_q;
  logic [SUM_W-1:0]         sum_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     overrun_q;

  cfg_edge_sync #(
    .SEL_W (CH_W)
  ) u_cfg_sync (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_clk_i  (cfg_clk),
    .cfg_data_i (cfg_data),
    .cfg_sel_i  (cfg_sel),
    .rise_o     (cfg_rise_s),
    .data_o     (cfg_data_s),
    .sel_o      (cfg_sel_s)
  );

  assign data_ext_s = SUM_W'($signed(buf_data));
  assign ch_next_s  = ch_q + ONE_CH;

  // Next shadow contents: one MSB-first shift into an in-range channel
  always_comb begin
    for (int i = 0; i < MAX_CH; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (cfg_rise_s && ({1'b0, cfg_sel_s} < NUM_CH_EXT)) begin
      shadow_d[cfg_sel_s] = {shadow_q[cfg_sel_s][IDX_W-2:0], cfg_data_s};
    end else begin
      shadow_d[0] = shadow_q[0];
    end
  end

  // Shadow delay registers, written only by the config path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // Frame sequencer: commit, walk channels, accumulate, publish the sum.
  // Commit samples shadow_q, so a shift landing on the same edge is deferred
  // to the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      acc_q      <= '0;
      chan_sel_q <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
        active_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_strobe) begin
            for (int i = 0; i < MAX_CH; i++) begin
              if (i < NUM_CHANNELS) begin
                active_q[i] <= clamp_index(shadow_q[i]);
              end else begin
                active_q[i] <= '0;
              end
            end
            ch_q       <= '0;
            acc_q      <= '0;
            chan_sel_q <= '0;
            idx_q      <= clamp_index(shadow_q[0]);
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (frame_strobe) begin
            overrun_q <= 1'b1;
          end else begin
            overrun_q <= overrun_q;
          end
          acc_q <= acc_q + data_ext_s;
          if (ch_q == LAST_CH) begin
            state_q <= ST_DONE;
          end else begin
            // Present the next channel's committed index for the next cycle.
            ch_q       <= ch_next_s;
            chan_sel_q <= ch_next_s;
            idx_q      <= active_q[ch_next_s];
            state_q    <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (frame_strobe) begin
            overrun_q <= 1'b1;
          end else begin
            overrun_q <= overrun_q;
          end
          sum_q      <= acc_q;
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          ch_q       <= '0;
          chan_sel_q <= '0;
          idx_q      <= active_q[0];
          state_q    <= ST_IDLE;
        end
        default: begin
          busy_q     <= 1'b0;
          ch_q       <= '0;
          chan_sel_q <= '0;
          idx_q      <= active_q[0];
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign buf_chan_sel   = chan_sel_q;
  assign buf_read_index = idx_q;
  assign sum_out        = sum_q;
  assign sum_valid      = valid_q;
  assign busy           = busy_q;
  assign frame_overrun  = overrun_q;

endmodule
